// File: rtl/flash_sched_pkg.sv
// Shared constants, state encoding and bar helpers for the sweep scheduler.
package flash_sched_pkg;

    localparam int NUM_REQ   = 2;
    localparam int MAX_STEPS = 8;
    localparam int LED_W     = 16;
    localparam int BOUND_W   = 5;
    localparam int STEP_W    = $clog2(MAX_STEPS);
    localparam int NSTEP_W   = STEP_W + 1;

    typedef logic [1:0]         state_t;
    typedef logic [BOUND_W-1:0] bound_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t UP     = 2'd1;
    localparam state_t DOWN   = 2'd2;
    localparam state_t FINISH = 2'd3;

    localparam bound_t LVL_MAX = bound_t'(LED_W);
    localparam bound_t HI_RST  = bound_t'(LED_W);
    localparam bound_t LO_RST  = bound_t'(0);

    localparam logic [NSTEP_W-1:0] NSTEPS_RST = NSTEP_W'(1);
    localparam logic [NSTEP_W-1:0] NSTEPS_MAX = NSTEP_W'(MAX_STEPS);

    localparam logic [LED_W:0] BAR_ONE = (LED_W+1)'(1);

    function automatic bound_t clamp_bound(input bound_t v);
        return (v > LVL_MAX) ? LVL_MAX : v;
    endfunction

    // One extra bit lets level == LED_W produce an all-ones bar.
    function automatic logic [LED_W-1:0] bar_enc(input bound_t lvl);
        logic [LED_W:0] t;
        t = (BAR_ONE << lvl) - BAR_ONE;
        return t[LED_W-1:0];
    endfunction

endpackage

// File: rtl/flash_sweep_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not
// win last time gets the bar.
module rr_arb2
    import flash_sched_pkg::*;
(
    input  logic               rr_ptr,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               winner,
    output logic               valid
);

    always_comb begin
        winner = 1'b0;
        unique case (1'b1)
            (req == 2'b11): winner = ~rr_ptr;
            (req == 2'b10): winner = 1'b1;
            default:        winner = 1'b0;
        endcase
        valid = |req;
        gnt   = '0;
        if (valid) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/flash_sweep_scheduler.sv
// Shares one thermometer LED bar between two requesters and plays a
// programmable series of up/down sweeps for each granted owner.
module flash_sweep_scheduler
    import flash_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               owner,
    output logic               busy,
    output logic               done,
    input  logic               abort,
    input  logic               cfg_we,
    input  logic [STEP_W-1:0]  cfg_addr,
    input  logic [BOUND_W-1:0] cfg_hi,
    input  logic [BOUND_W-1:0] cfg_lo,
    input  logic               cfg_nsteps_we,
    output logic               cfg_ack,
    output logic               cfg_err,
    output logic [LED_W-1:0]   LED
);

    state_t              state;
    state_t              state_nx;
    bound_t              level;
    bound_t              level_nx;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_nx;
    logic [NSTEP_W-1:0]  nsteps;
    logic                rr_ptr;
    bound_t              hi_tab [MAX_STEPS];
    bound_t              lo_tab [MAX_STEPS];

    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_win;
    logic                arb_valid;

    bound_t              cur_hi;
    bound_t              cur_lo;
    logic                last_step;
    logic                grant_now;
    logic                cfg_req;
    logic [NSTEP_W-1:0]  cfg_n;
    logic                nsteps_bad;
    logic                cfg_ok;

    rr_arb2 u_arb (
        .rr_ptr (rr_ptr),
        .req    (req),
        .gnt    (arb_gnt),
        .winner (arb_win),
        .valid  (arb_valid)
    );

    assign cur_hi    = hi_tab[step];
    assign cur_lo    = lo_tab[step];
    assign last_step = ({1'b0, step} == (nsteps - NSTEP_W'(1)));
    assign grant_now = (state == IDLE) && arb_valid;

    // A grant in the same cycle takes the idle slot, so the write loses.
    assign cfg_req    = cfg_we | cfg_nsteps_we;
    assign cfg_n      = cfg_hi[NSTEP_W-1:0];
    assign nsteps_bad = cfg_nsteps_we &&
                        ((cfg_n == '0) || (cfg_n > NSTEPS_MAX));
    assign cfg_ok     = (state == IDLE) && !arb_valid && !nsteps_bad;

    always_comb begin
        state_nx = state;
        level_nx = level;
        step_nx  = step;
        if ((state != IDLE) && abort) begin
            state_nx = IDLE;
            level_nx = '0;
            step_nx  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state_nx = UP;
                        level_nx = '0;
                        step_nx  = '0;
                    end
                end
                UP: begin
                    if (level < cur_hi) begin
                        level_nx = level + bound_t'(1);
                    end else begin
                        state_nx = DOWN;
                    end
                end
                DOWN: begin
                    if (level > cur_lo) begin
                        level_nx = level - bound_t'(1);
                    end else if (last_step) begin
                        state_nx = FINISH;
                    end else begin
                        step_nx  = step + STEP_W'(1);
                        state_nx = UP;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    level_nx = '0;
                    step_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            level   <= '0;
            step    <= '0;
            LED     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            owner   <= 1'b0;
            done    <= 1'b0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            rr_ptr  <= 1'b0;
            nsteps  <= NSTEPS_RST;
            for (int i = 0; i < MAX_STEPS; i++) begin
                hi_tab[i] <= HI_RST;
                lo_tab[i] <= LO_RST;
            end
        end else begin
            state   <= state_nx;
            level   <= level_nx;
            step    <= step_nx;
            LED     <= bar_enc(level_nx);
            gnt     <= grant_now ? arb_gnt : '0;
            done    <= (state == FINISH) && !abort;
            cfg_ack <= cfg_req && cfg_ok;
            cfg_err <= cfg_req && !cfg_ok;
            if (grant_now) begin
                busy   <= 1'b1;
                owner  <= arb_win;
                rr_ptr <= arb_win;
            end else if (state_nx == IDLE) begin
                busy <= 1'b0;
            end
            if (cfg_ok && cfg_we) begin
                hi_tab[cfg_addr] <= clamp_bound(cfg_hi);
                lo_tab[cfg_addr] <= clamp_bound(cfg_lo);
            end
            if (cfg_ok && cfg_nsteps_we) begin
                nsteps <= cfg_n;
            end
        end
    end

endmodule

// File: tb/tb_flash_sweep_scheduler.sv
// Directed bench for flash_sweep_scheduler: config vector table plus
// hand-built LED sweep sequences for grants, aborts and resets.
module tb_flash_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        owner;
    logic        busy;
    logic        done;
    logic        abort;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [4:0]  cfg_hi;
    logic [4:0]  cfg_lo;
    logic        cfg_nsteps_we;
    logic        cfg_ack;
    logic        cfg_err;
    logic [15:0] LED;

    int passed = 0;
    int total  = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic       we;
        logic       nwe;
        logic [2:0] addr;
        logic [4:0] hi;
        logic [4:0] lo;
        logic       ack;
        logic       err;
    } cfg_vec_t;

    cfg_vec_t vecs[8];

    flash_sweep_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .gnt           (gnt),
        .owner         (owner),
        .busy          (busy),
        .done          (done),
        .abort         (abort),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_hi        (cfg_hi),
        .cfg_lo        (cfg_lo),
        .cfg_nsteps_we (cfg_nsteps_we),
        .cfg_ack       (cfg_ack),
        .cfg_err       (cfg_err),
        .LED           (LED)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        total++;
        if (act === expv) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] bar(input int n);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k] = 1'b1;
        return r;
    endfunction

    task automatic build_sweep(input int hi, input int lo);
        exp_q.delete();
        for (int l = 1; l <= hi; l++) exp_q.push_back(bar(l));
        exp_q.push_back(bar(hi));
        for (int l = hi - 1; l >= lo; l--) exp_q.push_back(bar(l));
        exp_q.push_back(bar(lo));
    endtask

    task automatic build_prog2();
        int v[18] = '{1, 3, 7, 7, 3, 1, 1, 3, 7, 15, 31, 31, 15, 7, 3, 1, 0, 0};
        exp_q.delete();
        for (int i = 0; i < 18; i++) exp_q.push_back(16'(v[i]));
    endtask

    task automatic apply_cfg(input int idx);
        cfg_we        = vecs[idx].we;
        cfg_nsteps_we = vecs[idx].nwe;
        cfg_addr      = vecs[idx].addr;
        cfg_hi        = vecs[idx].hi;
        cfg_lo        = vecs[idx].lo;
        tick();
        cfg_we        = 1'b0;
        cfg_nsteps_we = 1'b0;
        check($sformatf("cfg[%0d] ack", idx), cfg_ack, vecs[idx].ack);
        check($sformatf("cfg[%0d] err", idx), cfg_err, vecs[idx].err);
    endtask

    // Plays exp_q after a grant; optionally injects a busy write or abort.
    task automatic run_seq(input string name, input int cfg_at,
                           input int abort_at);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == cfg_at) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'd0;
                cfg_hi   = 5'd2;
                cfg_lo   = 5'd0;
            end
            if (i == abort_at) abort = 1'b1;
            tick();
            if (i == abort_at) begin
                abort = 1'b0;
                check({name, " abort led"}, LED, 16'h0);
                check({name, " abort busy"}, busy, 1'b0);
                check({name, " abort done"}, done, 1'b0);
                return;
            end
            if (i == cfg_at) begin
                cfg_we = 1'b0;
                check({name, " busy cfg_err"}, cfg_err, 1'b1);
                check({name, " busy cfg_ack"}, cfg_ack, 1'b0);
            end
            check($sformatf("%s led[%0d]", name, i), LED, exp_q[i]);
            check($sformatf("%s busy[%0d]", name, i), busy, 1'b1);
        end
        tick();
        check({name, " done"}, done, 1'b1);
        check({name, " end busy"}, busy, 1'b0);
        check({name, " end led"}, LED, 16'h0);
    endtask

    initial begin
        vecs[0] = '{we: 1, nwe: 0, addr: 0, hi: 3,  lo: 1,  ack: 1, err: 0};
        vecs[1] = '{we: 1, nwe: 1, addr: 1, hi: 2,  lo: 0,  ack: 1, err: 0};
        vecs[2] = '{we: 1, nwe: 0, addr: 1, hi: 5,  lo: 0,  ack: 1, err: 0};
        vecs[3] = '{we: 0, nwe: 1, addr: 0, hi: 0,  lo: 0,  ack: 0, err: 1};
        vecs[4] = '{we: 0, nwe: 1, addr: 0, hi: 9,  lo: 0,  ack: 0, err: 1};
        vecs[5] = '{we: 0, nwe: 1, addr: 0, hi: 16, lo: 0,  ack: 0, err: 1};
        vecs[6] = '{we: 1, nwe: 0, addr: 0, hi: 20, lo: 14, ack: 1, err: 0};
        vecs[7] = '{we: 0, nwe: 1, addr: 0, hi: 1,  lo: 0,  ack: 1, err: 0};

        rst = 1'b1; req = '0; abort = 1'b0;
        cfg_we = 1'b0; cfg_nsteps_we = 1'b0;
        cfg_addr = '0; cfg_hi = '0; cfg_lo = '0;
        tick();
        tick();
        check("rst led", LED, 16'h0);
        check("rst gnt", gnt, 2'b00);
        check("rst busy", busy, 1'b0);
        check("rst owner", owner, 1'b0);
        check("rst done", done, 1'b0);
        check("rst ack", cfg_ack, 1'b0);
        check("rst err", cfg_err, 1'b0);
        rst = 1'b0;
        tick();
        check("idle busy", busy, 1'b0);

        // Default table, single requester, busy write must bounce.
        req = 2'b01;
        tick();
        check("g1 gnt", gnt, 2'b01);
        check("g1 busy", busy, 1'b1);
        check("g1 owner", owner, 1'b0);
        check("g1 led", LED, 16'h0);
        req = 2'b00;
        build_sweep(16, 0);
        run_seq("default", 2, -1);
        tick();
        check("post done", done, 1'b0);

        for (int i = 0; i < 6; i++) apply_cfg(i);

        // Tie with rr_ptr=0 goes to requester 1, then back to 0.
        req = 2'b11;
        tick();
        check("tie1 gnt", gnt, 2'b10);
        check("tie1 owner", owner, 1'b1);
        check("tie1 busy", busy, 1'b1);
        check("tie1 led", LED, 16'h0);
        build_prog2();
        run_seq("prog2a", -1, -1);
        tick();
        check("tie2 gnt", gnt, 2'b01);
        check("tie2 owner", owner, 1'b0);
        check("tie2 busy", busy, 1'b1);
        req = 2'b00;
        run_seq("prog2b", -1, -1);

        // Grant beats a simultaneous config write.
        req      = 2'b10;
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_hi   = 5'd4;
        cfg_lo   = 5'd0;
        tick();
        cfg_we = 1'b0;
        req    = 2'b00;
        check("coll gnt", gnt, 2'b10);
        check("coll err", cfg_err, 1'b1);
        check("coll ack", cfg_ack, 1'b0);
        check("coll owner", owner, 1'b1);
        run_seq("prog2c", -1, -1);

        // hi=20 is clamped to 16.
        apply_cfg(6);
        apply_cfg(7);
        req = 2'b01;
        tick();
        check("clamp gnt", gnt, 2'b01);
        req = 2'b00;
        build_sweep(16, 14);
        run_seq("clamp", -1, -1);

        // Reset in the middle of a DOWN ramp.
        req = 2'b01;
        tick();
        check("mid gnt", gnt, 2'b01);
        req = 2'b00;
        repeat (18) tick();
        check("mid down led", LED, bar(15));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst led", LED, 16'h0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst gnt", gnt, 2'b00);
        check("mid rst done", done, 1'b0);
        check("mid rst owner", owner, 1'b0);
        tick();
        check("mid idle busy", busy, 1'b0);

        req = 2'b01;
        tick();
        check("post rst gnt", gnt, 2'b01);
        req = 2'b00;
        build_sweep(16, 0);
        run_seq("post_rst", -1, -1);

        // Abort in UP while the bar shows 0x00FF.
        req = 2'b10;
        tick();
        check("ab gnt", gnt, 2'b10);
        check("ab owner", owner, 1'b1);
        req = 2'b00;
        run_seq("abort", -1, 8);
        tick();
        check("ab after done", done, 1'b0);
        check("ab after busy", busy, 1'b0);

        req = 2'b01;
        tick();
        check("regrant gnt", gnt, 2'b01);
        check("regrant busy", busy, 1'b1);
        check("regrant led", LED, 16'h0);
        req = 2'b00;
        run_seq("regrant", -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
